u_xmit: RTL

UART transmitter: accepts one parallel byte per request and serializes it on the UART TX pin as an asynchronous frame with one start bit, data LSB first, optional even parity, and stop bit(s). It sits next to the UART receiver on the same 16×-baud system clock, so one clock domain serves both directions. It has no FIFO: the host must wait for `xmit_doneH` before issuing the next request.

---
 rtl/u_xmit_if.sv | 22 ++
 rtl/u_xmit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/u_xmit_if.sv
// Host-side handshake and serial line of the UART transmitter.
// master: request source (host); slave: the transmitter itself.
interface u_xmit_if;
   logic       xmitH;
   logic [7:0] xmit_dataH;
   logic       xmit_doneH;
   logic       uart_xmitH;

   modport master (
      output xmitH,
      output xmit_dataH,
      input  xmit_doneH,
      input  uart_xmitH
   );

   modport slave (
      input  xmitH,
      input  xmit_dataH,
      output xmit_doneH,
      output uart_xmitH
   );
endinterface

// File: rtl/u_xmit.sv
// UART transmitter: start bit, WORD_LEN data bits LSB first, optional even parity, stop bit(s).
// Define XMIT_PARITY_EN to compile in the even-parity cell between data and stop.
module u_xmit #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned WORD_LEN     = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic    sys_clk,
   input  logic    sys_rst_l,
   u_xmit_if.slave xif
);

   localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      DataLast = 3'(WORD_LEN - 1);
   localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);
   localparam logic [7:0]      DataMask = 8'((1 << WORD_LEN) - 1);

   typedef enum logic [2:0] {
      XIdle   = 3'd0,
      XStart  = 3'd1,
      XData   = 3'd2,
`ifdef XMIT_PARITY_EN
      XParity = 3'd3,
`endif
      XStop   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            line_q, line_d;
   logic            done_q, done_d;
   logic            cell_end;
`ifdef XMIT_PARITY_EN
   logic            par_q, par_d;
`endif

   assign cell_end = (cnt_q == CntLast);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef XMIT_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         XIdle: begin
            if (xif.xmitH) begin
               state_d = XStart;
               shift_d = xif.xmit_dataH & DataMask;
               cnt_d   = '0;
               bit_d   = '0;
`ifdef XMIT_PARITY_EN
               par_d   = ^(xif.xmit_dataH & DataMask);
`endif
            end
         end
         XStart: begin
            if (cell_end) begin
               state_d = XData;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         XData: begin
            if (cell_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == DataLast) begin
`ifdef XMIT_PARITY_EN
                  state_d = XParity;
`else
                  state_d = XStop;
`endif
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
`ifdef XMIT_PARITY_EN
         XParity: begin
            if (cell_end) begin
               state_d = XStop;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
`endif
         XStop: begin
            // bit_q counts stop cells here
            if (cell_end) begin
               cnt_d = '0;
               if (bit_q == StopLast) begin
                  state_d = XIdle;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = XIdle;
            cnt_d   = '0;
            bit_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so the line is a clean flop output.
      line_d = 1'b1;
      case (state_d)
         XStart:  line_d = 1'b0;
         XData:   line_d = shift_d[0];
`ifdef XMIT_PARITY_EN
         XParity: line_d = par_d;
`endif
         default: line_d = 1'b1;
      endcase
      done_d = (state_d == XIdle);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         state_q <= XIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
         done_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         line_q  <= line_d;
         done_q  <= done_d;
      end
   end

`ifdef XMIT_PARITY_EN
   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) par_q <= 1'b0;
      else            par_q <= par_d;
   end
`endif

   assign xif.uart_xmitH = line_q;
   assign xif.xmit_doneH = done_q;

endmodule
